// File: rtl/conway_frame_serializer_if.sv
// Cell stream interface for conway_frame_serializer: valid/ready handshake carrying one
// board cell per transfer, tagged with its row/column and an end-of-frame marker.
interface conway_frame_serializer_if #(
   parameter int unsigned RW = 3,
   parameter int unsigned CW = 3
);
   logic          out_valid;
   logic          out_ready;
   logic          out_bit;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          out_last;

   modport master (
      output out_valid,
      output out_bit,
      output out_row,
      output out_col,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_bit,
      input  out_row,
      input  out_col,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/conway_frame_serializer.sv
// Snapshots the Game of Life board and streams it cell by cell in row-major order over a
// valid/ready interface. Optional live-cell counter enabled by `define CONWAY_SER_POPCOUNT_EN.
module conway_frame_serializer #(
   parameter int unsigned ROWS = 8,
   parameter int unsigned COLS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     capture_i,
   input  logic [ROWS*COLS-1:0]     cells_i,
   conway_frame_serializer_if.master out_if,
   output logic                     busy_o,
   output logic                     overrun_o
`ifdef CONWAY_SER_POPCOUNT_EN
   ,
   output logic [$clog2(ROWS*COLS+1)-1:0] pop_count_o,
   output logic                     pop_valid_o
`endif
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  shadow_q, shadow_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          overrun_q, overrun_d;

   logic          shifting;
   logic          at_end;
   logic          xfer;
   logic [IW-1:0] idx;

   // Output decode from registered state only; out_ready never reaches out_valid.
   always_comb begin
      shifting = (state_q == StShift);
      at_end   = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
      xfer     = shifting && out_if.out_ready;
      idx      = IW'(row_q) * IW'(COLS) + IW'(col_q);

      out_if.out_valid = shifting;
      out_if.out_bit   = shifting & shadow_q[idx];
      out_if.out_row   = row_q;
      out_if.out_col   = col_q;
      out_if.out_last  = shifting & at_end;
      busy_o           = shifting;
      overrun_o        = overrun_q;
   end

   // Next-state: capture in idle, row-major counter walk on each transfer in shift.
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      row_d     = row_q;
      col_d     = col_q;
      overrun_d = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (capture_i) begin
               shadow_d = cells_i;
               row_d    = '0;
               col_d    = '0;
               state_d  = StShift;
            end
         end
         StShift: begin
            // A capture here is dropped, including on the final transfer cycle.
            if (capture_i) begin
               overrun_d = 1'b1;
            end
            if (out_if.out_ready) begin
               if (at_end) begin
                  row_d   = '0;
                  col_d   = '0;
                  state_d = StIdle;
               end else if (col_q == CW'(COLS - 1)) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shadow_q  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         row_q     <= row_d;
         col_q     <= col_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef CONWAY_SER_POPCOUNT_EN
   localparam int unsigned PW = $clog2(N + 1);

   logic [PW-1:0] pop_q, pop_d;
   logic          pop_valid_q, pop_valid_d;

   // Live-cell count accumulated from the emitted bits; held after the frame ends.
   always_comb begin
      pop_d       = pop_q;
      pop_valid_d = 1'b0;
      if (!shifting && capture_i) begin
         pop_d = '0;
      end else if (xfer) begin
         pop_d       = pop_q + PW'(out_if.out_bit);
         pop_valid_d = at_end;
      end
   end

   // Popcount registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_q       <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         pop_q       <= pop_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   assign pop_count_o = pop_q;
   assign pop_valid_o = pop_valid_q;
`endif

endmodule
